// File: rtl/pulse_event_arbiter.sv
// Round-robin arbiter funnelling one-cycle events from N_REQ requesters into a
// single pulse channel, keeping at least GAP low cycles between issued pulses.
module pulse_event_arbiter #(
    parameter int N_REQ = 4,
    parameter int GAP   = 3,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             ovf_clr,
    output logic             out_pulse,
    output logic [ID_W-1:0]  out_id,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] overflow,
    output logic             busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic [ID_W-1:0]    r_last;
    logic               r_out_pulse;
    logic [ID_W-1:0]    r_out_id;
    logic [N_REQ-1:0]   r_pending;
    logic [N_REQ-1:0]   r_overflow;

    logic [ID_W:0]      w_shamt;
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_winner;
    logic               w_found;
    logic               w_issue;
    logic [N_REQ-1:0]   w_grant;
    logic [N_REQ-1:0]   w_drop;

    // Rotate pending so bit 0 is the requester just after the last grant.
    assign w_shamt = {1'b0, r_last} + (ID_W+1)'(1);
    assign w_dbl   = {r_pending, r_pending} >> w_shamt;
    assign w_rot   = w_dbl[N_REQ-1:0];
    assign w_found = |r_pending;

    always_comb begin
        w_off = '0;
        for (int j = N_REQ-1; j >= 0; j--) begin
            if (w_rot[j]) w_off = ID_W'(j);
        end
    end

    assign w_sum    = w_shamt + {1'b0, w_off};
    assign w_winner = (w_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(w_sum - (ID_W+1)'(N_REQ))
                                                  : ID_W'(w_sum);

    assign w_issue = w_found && ((r_state == IDLE) || (r_cnt == 8'd0));
    assign w_grant = w_issue ? (N_REQ'(1) << w_winner) : '0;
    // A granted requester may re-request in the same cycle without dropping.
    assign w_drop  = req_pulse & r_pending & ~w_grant;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_last      <= ID_W'(N_REQ-1);
            r_out_pulse <= 1'b0;
            r_out_id    <= '0;
            r_pending   <= '0;
            r_overflow  <= '0;
        end else begin
            r_out_pulse <= 1'b0;
            r_pending   <= (r_pending & ~w_grant) | req_pulse;
            r_overflow  <= (r_overflow & ~{N_REQ{ovf_clr}}) | w_drop;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_out_pulse <= 1'b1;
                        r_out_id    <= w_winner;
                        r_last      <= w_winner;
                        r_cnt       <= 8'(GAP);
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (w_issue) begin
                        r_out_pulse <= 1'b1;
                        r_out_id    <= w_winner;
                        r_last      <= w_winner;
                        r_cnt       <= 8'(GAP);
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_pulse = r_out_pulse;
    assign out_id    = r_out_id;
    assign pending   = r_pending;
    assign overflow  = r_overflow;
    assign busy      = (r_state == HOLD) || (|r_pending);

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed bench for pulse_event_arbiter (N_REQ=4, GAP=3); cycle numbers in
// comments follow the scenario timelines, with requests driven in cycle 10.
module tb_pulse_event_arbiter;

    logic       clk;
    logic       n_rst;
    logic [3:0] req_pulse;
    logic       ovf_clr;
    logic       out_pulse;
    logic [1:0] out_id;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic       busy;

    int checks;
    int failures;

    pulse_event_arbiter #(.N_REQ(4), .GAP(3)) dut (
        .clk(clk), .n_rst(n_rst), .req_pulse(req_pulse), .ovf_clr(ovf_clr),
        .out_pulse(out_pulse), .out_id(out_id), .pending(pending),
        .overflow(overflow), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0; req_pulse = '0; ovf_clr = 1'b0;
        step(); step();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; req_pulse = '0; ovf_clr = 1'b0;
        #3;
        checks++; if (out_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", out_pulse); end
        checks++; if (out_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", out_id); end
        checks++; if (pending !== 4'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        checks++; if (overflow !== 4'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0000", overflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        do_reset();
        req_pulse = 4'b0100; step(); req_pulse = '0;                    // c11
        checks++; if (pending !== 4'b0100) begin failures++; $display("FAIL single_pend11 got=%b exp=0100", pending); end
        checks++; if (out_pulse !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", out_pulse); end
        step();                                                         // c12
        checks++; if (out_pulse !== 1'b1) begin failures++; $display("FAIL single_pulse got=%b exp=1", out_pulse); end
        checks++; if (out_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", out_id); end
        checks++; if (pending !== 4'b0) begin failures++; $display("FAIL single_pend12 got=%b exp=0000", pending); end
        for (int c = 13; c <= 15; c++) begin
            step();
            checks++; if (out_pulse !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL single_hold c%0d pulse=%b busy=%b exp pulse=0 busy=1", c, out_pulse, busy);
            end
        end
        step();                                                         // c16
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy16 got=%b exp=0", busy); end
    endtask

    task automatic test_all();
        logic       exp_p;
        logic [1:0] exp_id;
        do_reset();
        req_pulse = 4'b1111; step(); req_pulse = '0;                    // c11
        for (int c = 11; c <= 27; c++) begin
            exp_p = (c == 12) || (c == 16) || (c == 20) || (c == 24);
            checks++; if (out_pulse !== exp_p) begin
                failures++; $display("FAIL all_pulse c%0d got=%b exp=%b", c, out_pulse, exp_p);
            end
            if (exp_p) begin
                exp_id = 2'((c - 12) / 4);
                checks++; if (out_id !== exp_id) begin
                    failures++; $display("FAIL all_id c%0d got=%0d exp=%0d", c, out_id, exp_id);
                end
            end
            step();
        end
        checks++; if (overflow !== 4'b0) begin failures++; $display("FAIL all_ovf got=%b exp=0000", overflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL all_busy got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_pulse = 4'b0010; step(); req_pulse = '0;                    // c11
        step();                                                         // c12
        checks++; if (out_pulse !== 1'b1 || out_id !== 2'd1) begin
            failures++; $display("FAIL rr_first pulse=%b id=%0d exp pulse=1 id=1", out_pulse, out_id);
        end
        req_pulse = 4'b1001; step(); req_pulse = '0;                    // c13
        checks++; if (pending !== 4'b1001) begin failures++; $display("FAIL rr_pend got=%b exp=1001", pending); end
        repeat (3) step();                                              // c16
        checks++; if (out_pulse !== 1'b1 || out_id !== 2'd3) begin
            failures++; $display("FAIL rr_second pulse=%b id=%0d exp pulse=1 id=3", out_pulse, out_id);
        end
        repeat (3) step();                                              // c19
        checks++; if (out_pulse !== 1'b0) begin failures++; $display("FAIL rr_gap got=%b exp=0", out_pulse); end
        step();                                                         // c20
        checks++; if (out_pulse !== 1'b1 || out_id !== 2'd0) begin
            failures++; $display("FAIL rr_third pulse=%b id=%0d exp pulse=1 id=0", out_pulse, out_id);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        req_pulse = 4'b0011; step(); req_pulse = '0;                    // c11
        step();                                                         // c12
        checks++; if (out_pulse !== 1'b1 || out_id !== 2'd0) begin
            failures++; $display("FAIL ovf_first pulse=%b id=%0d exp pulse=1 id=0", out_pulse, out_id);
        end
        req_pulse = 4'b0010; step(); req_pulse = '0;                    // c13
        checks++; if (overflow !== 4'b0010) begin failures++; $display("FAIL ovf_set got=%b exp=0010", overflow); end
        checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL ovf_pend got=%b exp=0010", pending); end
        repeat (3) step();                                              // c16
        checks++; if (out_pulse !== 1'b1 || out_id !== 2'd1) begin
            failures++; $display("FAIL ovf_issue pulse=%b id=%0d exp pulse=1 id=1", out_pulse, out_id);
        end
        repeat (4) step();                                              // c20
        checks++; if (out_pulse !== 1'b0 || pending !== 4'b0) begin
            failures++; $display("FAIL ovf_single pulse=%b pend=%b exp pulse=0 pend=0000", out_pulse, pending);
        end
        checks++; if (overflow !== 4'b0010) begin failures++; $display("FAIL ovf_sticky got=%b exp=0010", overflow); end
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;                         // c21
        checks++; if (overflow !== 4'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0000", overflow); end
    endtask

    task automatic test_back_to_back();
        int npulse;
        do_reset();
        req_pulse = 4'b0001; step();                                    // c11, grant cycle
        step(); req_pulse = '0;                                         // c12
        checks++; if (out_pulse !== 1'b1 || out_id !== 2'd0) begin
            failures++; $display("FAIL b2b_first pulse=%b id=%0d exp pulse=1 id=0", out_pulse, out_id);
        end
        checks++; if (pending !== 4'b0001) begin failures++; $display("FAIL b2b_pend got=%b exp=0001", pending); end
        repeat (4) step();                                              // c16
        checks++; if (out_pulse !== 1'b1 || out_id !== 2'd0) begin
            failures++; $display("FAIL b2b_second pulse=%b id=%0d exp pulse=1 id=0", out_pulse, out_id);
        end
        npulse = 0;
        for (int c = 17; c <= 24; c++) begin
            step();
            if (out_pulse === 1'b1) npulse++;
        end
        checks++; if (npulse !== 0) begin failures++; $display("FAIL b2b_extra got=%0d exp=0", npulse); end
        checks++; if (overflow !== 4'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0000", overflow); end
    endtask

    task automatic test_reset_mid();
        int npulse;
        do_reset();
        req_pulse = 4'b0111; step(); req_pulse = '0;                    // c11
        step();                                                         // c12
        checks++; if (out_pulse !== 1'b1 || out_id !== 2'd0) begin
            failures++; $display("FAIL rst_mid_pulse pulse=%b id=%0d exp pulse=1 id=0", out_pulse, out_id);
        end
        step();                                                         // c13
        checks++; if (pending !== 4'b0110 || busy !== 1'b1) begin
            failures++; $display("FAIL rst_mid_pre pend=%b busy=%b exp pend=0110 busy=1", pending, busy);
        end
        #2 n_rst = 1'b0;
        #1;
        checks++; if (pending !== 4'b0 || busy !== 1'b0 || out_pulse !== 1'b0 || overflow !== 4'b0 || out_id !== 2'd0) begin
            failures++; $display("FAIL rst_mid_async pend=%b busy=%b pulse=%b ovf=%b id=%0d exp all 0",
                                 pending, busy, out_pulse, overflow, out_id);
        end
        step(); step();
        n_rst = 1'b1;
        npulse = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (out_pulse === 1'b1) npulse++;
        end
        checks++; if (npulse !== 0) begin failures++; $display("FAIL rst_mid_after got=%0d exp=0", npulse); end
        checks++; if (pending !== 4'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_mid_idle pend=%b busy=%b exp pend=0000 busy=0", pending, busy);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_all();
        test_round_robin();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
